// File: rtl/icache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// icache_fill_ctrl
//   Refill engine for the instruction cache. A fill command fetches DEPTH
//   consecutive words from instruction memory, one request at a time. Each
//   returned word is written into the cache write port one cycle after it
//   arrives. freeze stays high while the cache contents are inconsistent.
//
//   Optional feature macro: FILL_TIMEOUT_EN. When it is defined, a response
//   that does not arrive within TIMEOUT cycles aborts the fill. The abort
//   pulses fill_done and sets fill_err. When the macro is undefined, WAIT holds
//   indefinitely and fill_err is tied to 0.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   fill_start   fill command pulse (accepted only while idle)
//   fill_base    start byte address (bits [1:0] ignored)
//   mem_req      read request, with mem_addr = base + 4*cnt
//   mem_ready    memory accepts the request this cycle
//   mem_valid    read data valid; mem_rdata is the read data
//   wr_en        cache write strobe, with wr_idx and wr_data
//   freeze       stall both datapaths
//   fill_done    one-cycle completion pulse
//   fill_err     timeout abort flag
//
// Handshake: a request transfers on a cycle where mem_req && mem_ready.
//   mem_addr is held steady until that cycle. After a transfer, the request
//   stays outstanding until the first cycle with mem_valid. mem_valid is
//   ignored at any other time.
// -----------------------------------------------------------------------------
module icache_fill_ctrl #(
   parameter int DEPTH   = 12,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     fill_start,
   input  logic [ADDR_W-1:0]        fill_base,
   output logic                     mem_req,
   output logic [ADDR_W-1:0]        mem_addr,
   input  logic                     mem_ready,
   input  logic                     mem_valid,
   input  logic [DATA_W-1:0]        mem_rdata,
   output logic                     wr_en,
   output logic [$clog2(DEPTH)-1:0] wr_idx,
   output logic [DATA_W-1:0]        wr_data,
   output logic                     freeze,
   output logic                     fill_done,
   output logic                     fill_err
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  cnt_q;
   logic [ADDR_W-1:0] base_q;
   logic              accept;
   logic              resp;
   logic              timeout_hit;

   assign accept = (state_q == S_IDLE) && fill_start;
   assign resp   = (state_q == S_WAIT) && mem_valid;

`ifdef FILL_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   logic [WAIT_W-1:0] wait_q;
   logic              err_q;

   // A response that arrives on the last allowed cycle still wins over the abort.
   assign timeout_hit = (state_q == S_WAIT) && !mem_valid &&
                        (wait_q == WAIT_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_q <= '0;
         err_q  <= 1'b0;
      end else begin
         if (state_q == S_WAIT) wait_q <= wait_q + WAIT_W'(1);
         else                   wait_q <= '0;
         if (accept)           err_q <= 1'b0;
         else if (timeout_hit) err_q <= 1'b1;
      end
   end

   assign fill_err = err_q;
`else
   assign timeout_hit = 1'b0;
   assign fill_err    = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (fill_start) state_d = S_REQ;
         S_REQ:  if (mem_ready)  state_d = S_WAIT;
         S_WAIT: begin
            if (mem_valid)        state_d = (cnt_q == LAST_IDX) ? S_DONE : S_REQ;
            else if (timeout_hit) state_d = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         base_q  <= '0;
         wr_en   <= 1'b0;
         wr_idx  <= '0;
         wr_data <= '0;
      end else begin
         state_q <= state_d;
         wr_en   <= resp;
         if (accept) begin
            cnt_q  <= '0;
            base_q <= {fill_base[ADDR_W-1:2], 2'b00};
         end
         if (resp) begin
            cnt_q   <= cnt_q + IDX_W'(1);
            wr_idx  <= cnt_q;
            wr_data <= mem_rdata;
         end
      end
   end

   // Address arithmetic wraps modulo 2^ADDR_W. The address is forced to 0
   // outside REQ so that an idle bus stays quiet.
   assign mem_req   = (state_q == S_REQ);
   assign mem_addr  = mem_req ? (base_q + ADDR_W'({cnt_q, 2'b00})) : '0;
   assign freeze    = (state_q != S_IDLE);
   assign fill_done = (state_q == S_DONE);

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icache_fill_ctrl
//   Bench for icache_fill_ctrl.
//   - A memory responder answers each accepted request with 0xA000_0000 | addr.
//     It can be ideal, stall a chosen address, behave randomly, or stay mute.
//   - The expected writes for a fill are derived from the base address:
//     entry i receives the data for (base & ~3) + 4*i.
//   - A write must appear exactly one cycle after each valid response.
//   - fill_done must coincide with the write of the final entry.
// -----------------------------------------------------------------------------
module tb_icache_fill_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        fill_start;
   logic [31:0] fill_base;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ready;
   logic        mem_valid;
   logic [31:0] mem_rdata;
   logic        wr_en;
   logic [3:0]  wr_idx;
   logic [31:0] wr_data;
   logic        freeze;
   logic        fill_done;
   logic        fill_err;

   icache_fill_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .fill_start (fill_start),
      .fill_base  (fill_base),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ready  (mem_ready),
      .mem_valid  (mem_valid),
      .mem_rdata  (mem_rdata),
      .wr_en      (wr_en),
      .wr_idx     (wr_idx),
      .wr_data    (wr_data),
      .freeze     (freeze),
      .fill_done  (fill_done),
      .fill_err   (fill_err)
   );

   // ---------------------------------------------------------------- clock/reset
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- memory responder
   logic        mute      = 1'b0;
   logic        rand_mode = 1'b0;
   logic [31:0] stall_addr = '0;
   int          stall_len  = 0;

   logic        pend = 1'b0;
   logic [31:0] pdata;
   int          dly;
   int          stall_cnt = 0;

   // Inputs change on the falling edge; the DUT outputs are stable there.
   always @(negedge clk) begin
      if (rst) begin
         pend      = 1'b0;
         mem_valid = 1'b0;
         mem_ready = 1'b0;
         stall_cnt = 0;
         mem_rdata = '0;
      end else begin
         mem_valid = 1'b0;
         mem_rdata = $urandom;
         if (pend && !mute) begin
            if (dly == 0) begin
               mem_valid = 1'b1;
               mem_rdata = pdata;
               pend      = 1'b0;
            end else begin
               dly--;
            end
         end
         if (!mem_req) begin
            stall_cnt = 0;
            mem_ready = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
         end else if (stall_len > 0 && mem_addr == stall_addr && stall_cnt < stall_len) begin
            mem_ready = 1'b0;
            stall_cnt++;
         end else if (rand_mode && $urandom_range(0, 3) == 0) begin
            mem_ready = 1'b0;
         end else begin
            mem_ready = 1'b1;
         end
         if (mem_req && mem_ready) begin
            pend  = 1'b1;
            pdata = 32'hA000_0000 | mem_addr;
            dly   = rand_mode ? int'($urandom_range(0, 2)) : 0;
         end
      end
   end

   // ---------------------------------------------------------------- scoreboard / driver
   logic [35:0] exp_q[$];       // {idx, data}
   logic [31:0] exp_addr_q[$];

   // Runs one fill. Offsets count from the cycle in which fill_start is presented (offset 0).
   // exp_done_k > 0 forces the expected fill_done offset (used for aborts).
   // rst_after > 0 resets the DUT right after that many writes have been seen.
   task automatic run_fill(input logic [31:0] base, input int pulse_at, input int rst_after,
                           input int exp_done_k, input int max_cyc,
                           output int done_off, output int n_wr);
      logic [31:0] eff;
      logic [31:0] a;
      logic [35:0] e;
      logic        prev_valid;
      logic        exp_done;
      eff = base & ~32'd3;
      exp_q.delete();
      exp_addr_q.delete();
      for (int i = 0; i < 12; i++) begin
         a = eff + 32'(4 * i);
         exp_addr_q.push_back(a);
         exp_q.push_back({4'(i), 32'hA000_0000 | a});
      end
      @(negedge clk); #1;
      fill_start = 1'b1;
      fill_base  = base;
      prev_valid = 1'b0;
      done_off   = -1;
      n_wr       = 0;
      for (int k = 1; k <= max_cyc && done_off < 0; k++) begin
         @(negedge clk); #1;
         if (k == 1) fill_start = 1'b0;
         if (k == pulse_at) begin
            fill_start = 1'b1;
            fill_base  = 32'h0000_0900;
         end
         if (k == pulse_at + 1) fill_start = 1'b0;
         check("freeze_busy", freeze, 1'b1);
         if (mem_req) begin
            if (exp_addr_q.size() == 0) check("extra_req", mem_req, 1'b0);
            else begin
               check("mem_addr", mem_addr, exp_addr_q[0]);
               if (mem_ready) void'(exp_addr_q.pop_front());
            end
         end
         check("wr_en", wr_en, prev_valid);
         if (wr_en) begin
            n_wr++;
            if (exp_q.size() == 0) check("extra_write", wr_en, 1'b0);
            else begin
               e = exp_q.pop_front();
               check("wr_idx", wr_idx, e[35:32]);
               check("wr_data", wr_data, e[31:0]);
            end
         end
         exp_done = (exp_done_k > 0) ? (k == exp_done_k) : (wr_en && exp_q.size() == 0);
         check("fill_done", fill_done, exp_done);
         if (fill_done) done_off = k;
         prev_valid = mem_valid;
         if (rst_after > 0 && n_wr == rst_after) begin
            rst = 1'b1;
            @(negedge clk); #1;
            rst = 1'b0;
            check("rst_mem_req", mem_req, 1'b0);
            check("rst_mem_addr", mem_addr, 32'h0);
            check("rst_wr_en", wr_en, 1'b0);
            check("rst_freeze", freeze, 1'b0);
            check("rst_fill_done", fill_done, 1'b0);
            check("rst_fill_err", fill_err, 1'b0);
            done_off = -2;
            return;
         end
      end
      if (done_off >= 0) begin
         @(negedge clk); #1;
         check("idle_freeze", freeze, 1'b0);
         check("idle_done", fill_done, 1'b0);
         check("idle_req", mem_req, 1'b0);
      end
   endtask

   // ---------------------------------------------------------------- vector table
   typedef struct {
      logic [31:0] base;
      logic [31:0] stall_addr;
      int          stall_len;
      int          pulse_at;
      int          exp_done;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int done_off;
      int n_wr;

      vecs[0] = '{32'h0000_0100, 32'h0, 0, -1, 25};           // ideal memory
      vecs[1] = '{32'h0000_0100, 32'h0000_010C, 5, -1, 30};   // word 3 stalled 5 cycles
      vecs[2] = '{32'h0000_0100, 32'h0, 0, 10, 25};           // stray fill_start ignored
      vecs[3] = '{32'hFFFF_FFF8, 32'h0, 0, -1, 25};           // address wrap
      vecs[4] = '{32'h0000_0FF4, 32'h0000_0FF4, 2, -1, 27};   // stall on first word
      vecs[5] = '{32'h7FFF_FFFF, 32'h8000_0028, 1, -1, 26};   // low bits dropped, stall last

      rst        = 1'b1;
      fill_start = 1'b0;
      fill_base  = '0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_mem_req", mem_req, 1'b0);
      check("reset_mem_addr", mem_addr, 32'h0);
      check("reset_wr_en", wr_en, 1'b0);
      check("reset_wr_idx", wr_idx, 4'h0);
      check("reset_wr_data", wr_data, 32'h0);
      check("reset_freeze", freeze, 1'b0);
      check("reset_fill_done", fill_done, 1'b0);
      check("reset_fill_err", fill_err, 1'b0);
      rst = 1'b0;

      for (int v = 0; v < 6; v++) begin
         stall_addr = vecs[v].stall_addr;
         stall_len  = vecs[v].stall_len;
         run_fill(vecs[v].base, vecs[v].pulse_at, 0, 0, 200, done_off, n_wr);
         check($sformatf("vec%0d_done_cycle", v), done_off, vecs[v].exp_done);
         check($sformatf("vec%0d_writes", v), n_wr, 12);
      end
      stall_len = 0;

      // A reset after the fifth write drops the fill; a new fill restarts at entry 0.
      run_fill(32'h0000_0100, -1, 5, 0, 200, done_off, n_wr);
      check("rst_fill_aborted", done_off, -2);
      run_fill(32'h0000_0200, -1, 0, 0, 200, done_off, n_wr);
      check("after_rst_done_cycle", done_off, 25);
      check("after_rst_writes", n_wr, 12);

      // Randomized memory timing and base addresses.
      rand_mode = 1'b1;
      for (int r = 0; r < 8; r++) begin
         run_fill($urandom, -1, 0, 0, 400, done_off, n_wr);
         check($sformatf("rand%0d_completed", r), done_off > 0, 1'b1);
         check($sformatf("rand%0d_writes", r), n_wr, 12);
      end
      rand_mode = 1'b0;

      // Memory never answers.
      mute = 1'b1;
`ifdef FILL_TIMEOUT_EN
      // Accepted at offset 1; WAIT spans offsets 2..65; the abort is at offset 66.
      run_fill(32'h0000_0040, -1, 0, 66, 100, done_off, n_wr);
      check("timeout_done_cycle", done_off, 66);
      check("timeout_writes", n_wr, 0);
      check("timeout_err_held", fill_err, 1'b1);
`else
      run_fill(32'h0000_0040, -1, 0, 0, 100, done_off, n_wr);
      check("no_timeout_done", done_off, -1);
      check("no_timeout_freeze", freeze, 1'b1);
      check("no_timeout_err", fill_err, 1'b0);
`endif
      rst = 1'b1;
      @(negedge clk); #1;
      rst  = 1'b0;
      mute = 1'b0;
      check("post_mute_freeze", freeze, 1'b0);
      check("post_mute_err", fill_err, 1'b0);
      run_fill(32'h0000_0300, -1, 0, 0, 200, done_off, n_wr);
      check("post_mute_done_cycle", done_off, 25);
      check("post_mute_fill_err", fill_err, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
